// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage sitting directly behind the program counter. It keeps
// at most one request outstanding to instruction memory, buffers the returned
// words (tagged with their fetch address) in a small FIFO toward decode, tells
// the PC when it may advance, and discards everything in flight on a flush.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   pc              current PC from the program counter
//   flush           branch taken: kill in-flight and buffered fetches
//   pc_stall        1 = PC must hold; 0 = PC advances (one per accepted fetch)
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request
//   imem_req_addr   fetch address, stable while the request is pending
//   imem_rsp_valid  response valid, one per accepted request
//   imem_rsp_data   returned instruction word
//   out_valid       instruction available to decode
//   out_ready       decode accepts the head entry
//   out_instr       head instruction (zero while empty)
//   out_pc          PC of the head instruction (zero while empty)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   flush,
  output logic                   pc_stall,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,     // no request pending
    REQ,      // request presented, waiting for ready
    WAIT,     // request accepted, waiting for the response
    DISCARD   // request accepted before a flush; swallow its response
  } state_t;

  state_t           state, state_next;
  logic             latch_addr;
  logic             push, pop;
  logic [CNT_W-1:0] count, count_next;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem    [FIFO_DEPTH];

  assign imem_req_valid = (state == REQ);
  assign pc_stall       = !(imem_req_valid && imem_req_ready && !flush);
  assign out_valid      = (count != '0);

  // A flush suppresses both FIFO operations in its cycle; the FIFO is cleared.
  assign push       = (state == WAIT) && imem_rsp_valid && !flush;
  assign pop        = out_valid && out_ready && !flush;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // NOTE: every output of this block gets a default before the case so that no
  // path leaves a signal unassigned and a latch is inferred.
  always_comb begin
    state_next = state;
    latch_addr = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && (count < DEPTH_CNT)) begin
          state_next = REQ;
          latch_addr = 1'b1;
        end
      end
      REQ: begin
        // Without ready the request is simply withdrawn; with ready it was
        // accepted and its response must still be absorbed.
        if (flush)               state_next = imem_req_ready ? DISCARD : IDLE;
        else if (imem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_next = imem_rsp_valid ? IDLE : DISCARD;
        end else if (imem_rsp_valid) begin
          // Room is judged on the occupancy after this cycle's push and pop.
          if (count_next < DEPTH_CNT) begin
            state_next = REQ;
            latch_addr = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        if (imem_rsp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      imem_req_addr <= '0;
    end else begin
      state <= state_next;
      if (latch_addr) imem_req_addr <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_next;
      // Depth is a power of two, so pointers wrap by plain overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through the head outputs, which are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= imem_req_addr;
    end
  end

  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

  // The issue rule reserves a slot for every accepted request, so a push can
  // never meet a full FIFO.
  push_not_full: assert property (@(posedge clk) disable iff (!rst)
    push |-> (count != DEPTH_CNT));

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage from a behavioural PC (advances by 4 whenever pc_stall is
// low, loads the target on flush) and a behavioural instruction memory (one
// pending request, configurable latency, data derived from the address).
// A transaction-level model tracks which fetched addresses must appear at the
// output and in what order.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int PW    = 16;
  localparam int IW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] pc;
  logic          flush;
  logic          pc_stall;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [PW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [PW-1:0] out_pc;

  fetch_stage #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_stall(pc_stall),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model
  bit            pend;
  int            pend_cnt;
  logic [PW-1:0] pend_addr;
  int            lat_max   = 1;
  logic [PW-1:0] slow_addr = 16'hFFFF;
  int            slow_lat  = 1;

  // Output-stream model
  logic [PW-1:0] q[$];
  bit            live;
  logic [PW-1:0] live_addr;
  logic [PW-1:0] pc_next;
  logic [PW-1:0] bad_pc = 16'hFFFF;
  bit            seen_bad;
  int            idle_run, max_idle_run, n_accept;

  // Values sampled in the most recent cycle
  logic          s_vld, s_stall, s_ov;
  logic [PW-1:0] s_addr, s_opc;
  logic [IW-1:0] s_instr;

  typedef struct {
    bit            rst_first;
    bit            rdy;
    bit            ordy;
    bit            e_vld;
    logic [PW-1:0] e_addr;
    bit            e_stall;
    bit            e_ov;
    logic [PW-1:0] e_opc;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [IW-1:0] instr_of(input logic [PW-1:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    live = 1'b0;
  endtask

  task automatic mem_step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend_addr);
        pend           = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    if (!imem_req_valid) check("stall_no_req", pc_stall, 1'b1);
    else begin
      check("stall_rule", pc_stall, !(imem_req_ready && !flush));
      check("req_addr_is_pc", imem_req_addr, pc);
      check("req_has_room", (q.size() < DEPTH) && !live, 1'b1);
    end
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_pc", out_pc, q[0]);
      check("out_instr", out_instr, instr_of(q[0]));
    end
    if (out_valid && out_pc == bad_pc) seen_bad = 1'b1;
  endtask

  task automatic model_update(input bit fl, input logic [PW-1:0] tgt);
    bit acc;
    acc = imem_req_valid && imem_req_ready;
    if (fl) begin
      q.delete();
      live = 1'b0;
    end else begin
      if (out_ready && q.size() != 0) void'(q.pop_front());
      if (imem_rsp_valid && live) begin
        q.push_back(live_addr);
        live = 1'b0;
      end
    end
    if (acc) begin
      check("one_outstanding", pend, 1'b0);
      pend      = 1'b1;
      pend_cnt  = (imem_req_addr == slow_addr) ? slow_lat : $urandom_range(lat_max, 1);
      pend_addr = imem_req_addr;
      live      = !fl;
      live_addr = imem_req_addr;
      n_accept++;
      idle_run  = 0;
    end else begin
      idle_run++;
      if (idle_run > max_idle_run) max_idle_run = idle_run;
    end
    pc_next = fl ? tgt : (pc_stall ? pc : pc + 16'd4);
  endtask

  // One clock cycle: entered just after a rising edge, returns just after the next.
  task automatic cyc(input bit rdy, input bit ordy, input bit fl, input logic [PW-1:0] tgt);
    mem_step();
    imem_req_ready = rdy;
    out_ready      = ordy;
    flush          = fl;
    @(negedge clk);
    s_vld = imem_req_valid; s_addr = imem_req_addr; s_stall = pc_stall;
    s_ov  = out_valid;      s_opc  = out_pc;        s_instr = out_instr;
    model_check();
    model_update(fl, tgt);
    @(posedge clk);
    #1;
    pc = pc_next;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_req_addr"},  imem_req_addr,  '0);
    check({tag, "_stall"},     pc_stall,       1'b1);
    check({tag, "_out_valid"}, out_valid,      1'b0);
    check({tag, "_out_instr"}, out_instr,      '0);
    check({tag, "_out_pc"},    out_pc,         '0);
  endtask

  task automatic do_reset(input logic [PW-1:0] pc0);
    rst = 1'b0;
    flush = 1'b0; imem_req_ready = 1'b0; out_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    pc = pc0; pc_next = pc0; pend = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Basic stream with a one-cycle memory, then back-pressure with DEPTH=2.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b1, 16'h0004};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b1, 16'h0008};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b1, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0004};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b0, 16'h0000};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0, 16'h0000};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b1, 16'h0008};

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].rst_first) do_reset(16'h0000);
      cyc(vecs[i].rdy, vecs[i].ordy, 1'b0, 16'h0000);
      check($sformatf("v%0d_req_valid", i), s_vld, vecs[i].e_vld);
      check($sformatf("v%0d_req_addr", i), s_addr, vecs[i].e_addr);
      check($sformatf("v%0d_stall", i), s_stall, vecs[i].e_stall);
      check($sformatf("v%0d_out_valid", i), s_ov, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_out_pc", i), s_opc, vecs[i].e_opc);
        check($sformatf("v%0d_out_instr", i), s_instr, instr_of(vecs[i].e_opc));
      end
    end

    // Flush while waiting on a slow response for 0x0008.
    do_reset(16'h0000);
    slow_addr = 16'h0008; slow_lat = 4; bad_pc = 16'h0008; seen_bad = 1'b0;
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      found = s_vld && (s_addr == 16'h0008);
    end
    check("wflush_req8_issued", found, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h0040);
    check("wflush_buffered_before", s_ov, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    check("wflush_fifo_emptied", s_ov, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      found = s_vld;
    end
    check("wflush_next_req_seen", found, 1'b1);
    check("wflush_next_addr", s_addr, 16'h0040);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      found = s_ov;
    end
    check("wflush_out_after", s_opc, 16'h0040);
    check("wflush_never_pc8", seen_bad, 1'b0);
    slow_addr = 16'hFFFF; bad_pc = 16'hFFFF;

    // Flush in the same cycle as the response.
    do_reset(16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 16'h0080);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    check("rflush_idle", s_vld, 1'b0);
    check("rflush_no_push", s_ov, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    check("rflush_req_valid", s_vld, 1'b1);
    check("rflush_req_addr", s_addr, 16'h0080);

    // Memory not ready for four cycles, then a withdrawing flush.
    do_reset(16'h0010);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      check($sformatf("hold%0d_valid", k), s_vld, 1'b1);
      check($sformatf("hold%0d_addr", k), s_addr, 16'h0010);
      check($sformatf("hold%0d_stall", k), s_stall, 1'b1);
    end
    cyc(1'b0, 1'b1, 1'b1, 16'h0200);
    check("withdraw_stall", s_stall, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    check("withdraw_idle", s_vld, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    check("withdraw_reissue_valid", s_vld, 1'b1);
    check("withdraw_reissue_addr", s_addr, 16'h0200);
    check("withdraw_reissue_stall", s_stall, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // Reset asserted in WAIT with one buffered entry; stray response afterwards.
    do_reset(16'h0000);
    slow_addr = 16'h0004; slow_lat = 4;
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    check("midrst_req4_accepted", s_vld && (s_addr == 16'h0004), 1'b1);
    mem_step();
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs("midrst");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      mem_step();
    end
    @(posedge clk);
    #1;
    mem_step();
    rst = 1'b1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("stray_req_valid", imem_req_valid, 1'b0);
    check("stray_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    slow_addr = 16'hFFFF;
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    check("midrst_first_req_valid", s_vld, 1'b1);
    check("midrst_first_req_addr", s_addr, 16'h0008);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      found = s_ov;
    end
    check("midrst_first_out_pc", s_opc, 16'h0008);

    // Randomized traffic against the model.
    do_reset(PW'($urandom) & 16'hFFFC);
    lat_max = 4; max_idle_run = 0; idle_run = 0; n_accept = 0;
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
          PW'($urandom) & 16'hFFFC);
    end
    check("rand_progress", max_idle_run < 60, 1'b1);
    check("rand_enough_fetches", n_accept > 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
